// File: rtl/lemming_arena.sv
// rtl/lemming_arena.sv - lemming walker arena: step prescaler, bounded position, wall bumps
// Optional bump_count output is enabled by defining LEMMING_ARENA_BUMP_COUNT_EN.
module lemming_arena #(
   parameter int CELLS     = 16,
   parameter int POS_W     = 4,
   parameter int STEP_DIV  = 4,
   parameter int START_POS = 8
) (
   input  logic             clk,
   input  logic             areset,
   input  logic             enable,
   input  logic             walk_left,
   input  logic             walk_right,
   output logic             bump_left,
   output logic             bump_right,
   output logic [POS_W-1:0] position,
`ifdef LEMMING_ARENA_BUMP_COUNT_EN
   output logic [7:0]       bump_count,
`endif
   output logic             dir_err
);

   localparam int PRE_W = (STEP_DIV > 2) ? $clog2(STEP_DIV) : 1;
   localparam logic [PRE_W-1:0] PRE_LAST  = PRE_W'(STEP_DIV - 1);
   localparam logic [POS_W-1:0] POS_LAST  = POS_W'(CELLS - 1);
   localparam logic [POS_W-1:0] POS_START = POS_W'(START_POS);

   logic [PRE_W-1:0] prescaler;
   logic             tick;
   logic             go_left;
   logic             go_right;
   logic             hit_left;
   logic             hit_right;

   // Movement is only ever evaluated on the tick cycle; a wall hit turns the step into a bump.
   always_comb begin
      tick      = enable && (prescaler == PRE_LAST);
      go_left   = tick && walk_left && !walk_right;
      go_right  = tick && walk_right && !walk_left;
      hit_left  = go_left && (position == '0);
      hit_right = go_right && (position == POS_LAST);
   end

   always_ff @(posedge clk) begin
      if (areset) begin
         prescaler  <= '0;
         position   <= POS_START;
         bump_left  <= 1'b0;
         bump_right <= 1'b0;
         dir_err    <= 1'b0;
      end else begin
         if (enable) begin
            prescaler <= tick ? '0 : prescaler + 1'b1;
         end
         if (go_left && !hit_left) begin
            position <= position - 1'b1;
         end else if (go_right && !hit_right) begin
            position <= position + 1'b1;
         end
         bump_left  <= hit_left;
         bump_right <= hit_right;
         if (tick && (walk_left == walk_right)) begin
            dir_err <= 1'b1;
         end
      end
   end

`ifdef LEMMING_ARENA_BUMP_COUNT_EN
   always_ff @(posedge clk) begin
      if (areset) begin
         bump_count <= '0;
      end else if ((hit_left || hit_right) && (bump_count != 8'hFF)) begin
         bump_count <= bump_count + 8'd1;
      end
   end
`endif

endmodule

// File: doc/lemming_arena.md
LEMMING_ARENA -- requirements
Module: lemming_arena

Interface
REQ-001 The parameter list SHALL be: CELLS, default 16, number of arena cells (min 2).
REQ-002 The parameter list SHALL also include: POS_W, default 4, width of the position register (2**POS_W >= CELLS).
REQ-003 The parameter list SHALL also include: STEP_DIV, default 4, clock cycles per lemming step (min 2).
REQ-004 The parameter list SHALL also include: START_POS, default 8, position loaded at reset (< CELLS).
REQ-005 The block SHALL have port: clk  input  1  single clock, all logic on rising edge.
REQ-006 The block SHALL have port: areset  input  1  synchronous active-high reset.
REQ-007 The block SHALL have port: enable  input  1  step prescaler runs while high.
REQ-008 The block SHALL have port: walk_left  input  1  lemming walking-left indication.
REQ-009 The block SHALL have port: walk_right  input  1  lemming walking-right indication.
REQ-010 The block SHALL have port: bump_left  output  1  registered one-cycle bump from the left wall.
REQ-011 The block SHALL have port: bump_right  output  1  registered one-cycle bump from the right wall.
REQ-012 The block SHALL have port: position  output  POS_W  current lemming cell, 0 = left wall.
REQ-013 The block SHALL have port: dir_err  output  1  sticky flag, illegal direction seen.

Function
REQ-014 Prescaler SHALL count 0..STEP_DIV-1 while enable=1, wrap to 0, and hold its value while enable=0.
REQ-015 A step tick SHALL occur on the cycle where prescaler==STEP_DIV-1 and enable=1; no other cycle evaluates movement.
REQ-016 On a tick with walk_left=1, walk_right=0, position>0: position SHALL decrement by 1 at that edge.
REQ-017 On a tick with walk_left=1, walk_right=0, position==0: position SHALL hold and bump_left SHALL be 1 for exactly the following cycle.
REQ-018 On a tick with walk_right=1, walk_left=0, position<CELLS-1: position SHALL increment by 1.
REQ-019 On a tick with walk_right=1, walk_left=0, position==CELLS-1: position SHALL hold and bump_right SHALL be 1 for exactly the following cycle.
REQ-020 On a tick with walk_left==walk_right: position SHALL hold, no bump SHALL issue, and dir_err SHALL set to 1 and stay set until reset.
REQ-021 bump_left and bump_right SHALL never be high in the same cycle and SHALL be 0 on every non-tick cycle's following cycle.
REQ-022 Position SHALL never wrap: 0 and CELLS-1 are hard limits.
REQ-023 Bump-to-response: the walker samples the bump at the edge after it asserts; STEP_DIV>=2 SHALL guarantee the new direction is present before the next tick.
REQ-024 Dropping enable mid-count SHALL freeze the prescaler without losing the partial count; an already-issued bump still completes its single cycle.

Reset
REQ-025 On a clk edge with areset=1: position=START_POS, prescaler=0, bump_left=0, bump_right=0, dir_err=0.
REQ-026 Reset SHALL override a simultaneous tick; no move and no bump SHALL result from that edge.
REQ-027 Reset asserted while a bump is high SHALL clear it on the reset edge.

Configuration
REQ-028 Macro LEMMING_ARENA_BUMP_COUNT_EN defined: extra output port bump_count (8 bits) SHALL count issued bumps (both walls), saturate at 255, and clear on reset.
REQ-029 Macro LEMMING_ARENA_BUMP_COUNT_EN undefined: port and counter SHALL be absent; all other behaviour identical.

Verification
REQ-030 Defaults, reset, enable=1, walk_right=1 held -> position 8->15 over 7 ticks (one per 4 cycles); next tick -> bump_right high exactly 1 cycle, position stays 15.
REQ-031 Closed loop with the walker FSM, start walking left from reset -> bump_left at position 0, walker turns right; position reaches 15, bump_right; period repeats with no double bumps.
REQ-032 walk_left=walk_right=1 on a tick -> position unchanged, dir_err=1, remains 1 after directions are legal again until areset.
REQ-033 enable dropped at prescaler=2 for 10 cycles -> no move; re-enable -> tick 2 cycles later (at count 3).
REQ-034 areset asserted on a tick cycle at position 0 walking left -> no bump, position=8 next cycle.
REQ-035 With LEMMING_ARENA_BUMP_COUNT_EN, 300 forced wall bumps (CELLS=2) -> bump_count=255 and holds.
